// File: rtl/jtag_tap_pkg.sv
// Shared TAP types: the 16-state IEEE 1149.1 controller encoding and the IDCODE opcode.
// Imported by the TAP FSM and the multi-chain TAP top.
package jtag_tap_pkg;

    typedef enum logic [3:0] {
        TestLogicReset,
        RunTestIdle,
        SelectDrScan,
        CaptureDr,
        ShiftDr,
        Exit1Dr,
        PauseDr,
        Exit2Dr,
        UpdateDr,
        SelectIrScan,
        CaptureIr,
        ShiftIr,
        Exit1Ir,
        PauseIr,
        Exit2Ir,
        UpdateIr
    } tap_state_e;

    localparam int unsigned IdcodeOpcode = 1;

endpackage

// File: rtl/cluster_clock_inverter.sv
// Clock inverter cell wrapper; zero latency, no flow control.
module cluster_clock_inverter (
    input  logic clk_i,
    output logic clk_o
);

    assign clk_o = ~clk_i;

endmodule

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller: one state step per rising TCK, strobes decoded from current state only.
// Strobes are combinational (zero latency); JTAG has no backpressure.
module jtag_tap_fsm
    import jtag_tap_pkg::*;
(
    input  logic tck_i,
    input  logic trst_ni,
    input  logic tms_i,
    output logic capture_dr_o,
    output logic shift_dr_o,
    output logic update_dr_o,
    output logic capture_ir_o,
    output logic shift_ir_o,
    output logic update_ir_o,
    output logic tlr_o
);

    tap_state_e r_state;
    tap_state_e w_state_next;

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            r_state <= TestLogicReset;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            TestLogicReset: w_state_next = tms_i ? TestLogicReset : RunTestIdle;
            RunTestIdle:    w_state_next = tms_i ? SelectDrScan   : RunTestIdle;
            SelectDrScan:   w_state_next = tms_i ? SelectIrScan   : CaptureDr;
            CaptureDr:      w_state_next = tms_i ? Exit1Dr        : ShiftDr;
            ShiftDr:        w_state_next = tms_i ? Exit1Dr        : ShiftDr;
            Exit1Dr:        w_state_next = tms_i ? UpdateDr       : PauseDr;
            PauseDr:        w_state_next = tms_i ? Exit2Dr        : PauseDr;
            Exit2Dr:        w_state_next = tms_i ? UpdateDr       : ShiftDr;
            UpdateDr:       w_state_next = tms_i ? SelectDrScan   : RunTestIdle;
            SelectIrScan:   w_state_next = tms_i ? TestLogicReset : CaptureIr;
            CaptureIr:      w_state_next = tms_i ? Exit1Ir        : ShiftIr;
            ShiftIr:        w_state_next = tms_i ? Exit1Ir        : ShiftIr;
            Exit1Ir:        w_state_next = tms_i ? UpdateIr       : PauseIr;
            PauseIr:        w_state_next = tms_i ? Exit2Ir        : PauseIr;
            Exit2Ir:        w_state_next = tms_i ? UpdateIr       : ShiftIr;
            UpdateIr:       w_state_next = tms_i ? SelectDrScan   : RunTestIdle;
            default:        w_state_next = TestLogicReset;
        endcase
    end

    always_comb begin
        capture_dr_o = 1'b0;
        shift_dr_o   = 1'b0;
        update_dr_o  = 1'b0;
        capture_ir_o = 1'b0;
        shift_ir_o   = 1'b0;
        update_ir_o  = 1'b0;
        tlr_o        = 1'b0;
        case (r_state)
            TestLogicReset: tlr_o        = 1'b1;
            CaptureDr:      capture_dr_o = 1'b1;
            ShiftDr:        shift_dr_o   = 1'b1;
            UpdateDr:       update_dr_o  = 1'b1;
            CaptureIr:      capture_ir_o = 1'b1;
            ShiftIr:        shift_ir_o   = 1'b1;
            UpdateIr:       update_ir_o  = 1'b1;
            default:        ;
        endcase
    end

endmodule

// File: rtl/pulp_clock_mux2.sv
// Two-input clock mux cell wrapper; clk_sel_i=1 selects clk1_i. Zero latency, no flow control.
module pulp_clock_mux2 (
    input  logic clk0_i,
    input  logic clk1_i,
    input  logic clk_sel_i,
    output logic clk_o
);

    assign clk_o = clk_sel_i ? clk1_i : clk0_i;

endmodule

// File: rtl/jtag_tap_multi.sv
// JTAG TAP with IR, IDCODE/BYPASS DRs and NumUserDr external user chains selected by opcode.
// td_o is registered on falling TCK (rising in testmode); JTAG has no backpressure.
module jtag_tap_multi
    import jtag_tap_pkg::*;
#(
    parameter int unsigned IrLength    = 5,
    parameter logic [31:0] IdcodeValue = 32'h00000001,
    parameter int unsigned NumUserDr   = 2,
    parameter int unsigned UserIrBase  = 'h10
) (
    input  logic                 tck_i,
    input  logic                 trst_ni,
    input  logic                 tms_i,
    input  logic                 td_i,
    output logic                 td_o,
    output logic                 tdo_oe_o,
    input  logic                 testmode_i,
    output logic                 tck_o,
    output logic                 trst_no,
    output logic                 tdi_o,
    output logic                 capture_o,
    output logic                 shift_o,
    output logic                 update_o,
    output logic [NumUserDr-1:0] user_select_o,
    input  logic [NumUserDr-1:0] user_tdo_i,
    output logic                 tlr_o,
    output logic [IrLength-1:0]  ir_o
);

    localparam logic [IrLength-1:0] IrIdcode  = IrLength'(IdcodeOpcode);
    localparam logic [IrLength-1:0] IrCapture = {{(IrLength-2){1'b0}}, 2'b01};

    if (IrLength < 3 || IrLength > 8) begin : g_bad_ir_length
        $error("jtag_tap_multi: IrLength must be within 3..8");
    end
    if (NumUserDr < 1 || NumUserDr > 8) begin : g_bad_num_user
        $error("jtag_tap_multi: NumUserDr must be within 1..8");
    end
    if (UserIrBase + NumUserDr - 1 >= (1 << IrLength) - 1) begin : g_bad_user_base
        $error("jtag_tap_multi: user opcodes collide with the all-ones BYPASS opcode");
    end
    if (IdcodeValue[0] != 1'b1) begin : g_bad_idcode
        $error("jtag_tap_multi: IdcodeValue bit 0 must be 1");
    end

    logic w_capture_dr, w_shift_dr, w_update_dr;
    logic w_capture_ir, w_shift_ir, w_update_ir;
    logic w_tlr;

    jtag_tap_fsm i_fsm (
        .tck_i        (tck_i),
        .trst_ni      (trst_ni),
        .tms_i        (tms_i),
        .capture_dr_o (w_capture_dr),
        .shift_dr_o   (w_shift_dr),
        .update_dr_o  (w_update_dr),
        .capture_ir_o (w_capture_ir),
        .shift_ir_o   (w_shift_ir),
        .update_ir_o  (w_update_ir),
        .tlr_o        (w_tlr)
    );

    logic [IrLength-1:0] r_ir_shift;
    logic [IrLength-1:0] r_ir_active;

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            r_ir_shift  <= '0;
            r_ir_active <= IrIdcode;
        end else begin
            if (w_tlr) begin
                r_ir_active <= IrIdcode;
            end else if (w_update_ir) begin
                r_ir_active <= r_ir_shift;
            end
            if (w_capture_ir) begin
                r_ir_shift <= IrCapture;
            end else if (w_shift_ir) begin
                r_ir_shift <= {td_i, r_ir_shift[IrLength-1:1]};
            end
        end
    end

    // All-zeros and all-ones are BYPASS even if a user opcode range would otherwise match.
    logic                 w_sel_idcode;
    logic                 w_sel_bypass;
    logic [NumUserDr-1:0] w_user_sel;

    always_comb begin
        w_sel_idcode = 1'b0;
        w_user_sel   = '0;
        if (r_ir_active == IrIdcode) begin
            w_sel_idcode = 1'b1;
        end else if (r_ir_active != '0 && r_ir_active != '1) begin
            for (int k = 0; k < NumUserDr; k++) begin
                if (r_ir_active == IrLength'(UserIrBase + k)) begin
                    w_user_sel[k] = 1'b1;
                end
            end
        end
    end

    assign w_sel_bypass = ~w_sel_idcode & ~(|w_user_sel);

    logic [31:0] r_idcode;
    logic        r_bypass;

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            r_idcode <= IdcodeValue;
            r_bypass <= 1'b0;
        end else begin
            if (w_capture_dr && w_sel_idcode) begin
                r_idcode <= IdcodeValue;
            end else if (w_shift_dr && w_sel_idcode) begin
                r_idcode <= {td_i, r_idcode[31:1]};
            end
            if (w_capture_dr && w_sel_bypass) begin
                r_bypass <= 1'b0;
            end else if (w_shift_dr && w_sel_bypass) begin
                r_bypass <= td_i;
            end
        end
    end

    logic w_tdo_mux;

    always_comb begin
        w_tdo_mux = r_bypass;
        if (w_shift_ir) begin
            w_tdo_mux = r_ir_shift[0];
        end else if (w_sel_idcode) begin
            w_tdo_mux = r_idcode[0];
        end else if (|w_user_sel) begin
            w_tdo_mux = |(w_user_sel & user_tdo_i);
        end
    end

    // Scan test runs the output stage on the true clock so the whole TAP sits in one clock domain.
    logic w_tck_n;
    logic w_tdo_clk;
    logic r_tdo;
    logic r_tdo_oe;

    cluster_clock_inverter i_tck_inv (
        .clk_i (tck_i),
        .clk_o (w_tck_n)
    );

    pulp_clock_mux2 i_tdo_clk_mux (
        .clk0_i    (w_tck_n),
        .clk1_i    (tck_i),
        .clk_sel_i (testmode_i),
        .clk_o     (w_tdo_clk)
    );

    always_ff @(posedge w_tdo_clk or negedge trst_ni) begin
        if (!trst_ni) begin
            r_tdo    <= 1'b0;
            r_tdo_oe <= 1'b0;
        end else begin
            r_tdo    <= w_tdo_mux;
            r_tdo_oe <= w_shift_ir | w_shift_dr;
        end
    end

    assign td_o          = r_tdo;
    assign tdo_oe_o      = r_tdo_oe;
    assign tck_o         = tck_i;
    assign trst_no       = trst_ni;
    assign tdi_o         = td_i;
    assign capture_o     = w_capture_dr;
    assign shift_o       = w_shift_dr;
    assign update_o      = w_update_dr;
    assign user_select_o = w_user_sel;
    assign tlr_o         = w_tlr;
    assign ir_o          = r_ir_active;

endmodule

// File: tb/tb_jtag_tap_multi.sv
// Directed bench for jtag_tap_multi with default parameters; expected values are hand-derived.
module tb_jtag_tap_multi;

    logic       tck = 1'b0;
    logic       trst_n;
    logic       tms;
    logic       tdi;
    logic       testmode;
    logic [1:0] user_tdo;

    logic       td_o, tdo_oe_o, tck_o, trst_no, tdi_o;
    logic       capture_o, shift_o, update_o, tlr_o;
    logic [1:0] user_select_o;
    logic [4:0] ir_o;

    int n_checks = 0;
    int n_fail   = 0;
    int upd_cnt  = 0;

    jtag_tap_multi dut (
        .tck_i         (tck),
        .trst_ni       (trst_n),
        .tms_i         (tms),
        .td_i          (tdi),
        .td_o          (td_o),
        .tdo_oe_o      (tdo_oe_o),
        .testmode_i    (testmode),
        .tck_o         (tck_o),
        .trst_no       (trst_no),
        .tdi_o         (tdi_o),
        .capture_o     (capture_o),
        .shift_o       (shift_o),
        .update_o      (update_o),
        .user_select_o (user_select_o),
        .user_tdo_i    (user_tdo),
        .tlr_o         (tlr_o),
        .ir_o          (ir_o)
    );

    always #10 tck = ~tck;

    always @(posedge update_o) upd_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    // One TCK cycle: inputs applied after the falling edge, outputs sampled just after the next falling edge.
    task automatic step(input logic t_ms, input logic t_di);
        tms = t_ms;
        tdi = t_di;
        @(posedge tck);
        @(negedge tck);
        #1;
    endtask

    // From RunTestIdle, shifts an IR value LSB-first and stops in Exit1Ir.
    task automatic load_ir(input logic [4:0] v);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(i == 4, v[i]);
    endtask

    task automatic test_reset;
        trst_n   = 1'b0;
        tms      = 1'b1;
        tdi      = 1'b0;
        testmode = 1'b0;
        user_tdo = 2'b00;
        #25;
        n_checks++;
        if ({tlr_o, ir_o, td_o, tdo_oe_o} !== {1'b1, 5'h01, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_asserted: got tlr/ir/tdo/oe=%b/%h/%b/%b want 1/01/0/0",
                     tlr_o, ir_o, td_o, tdo_oe_o);
        end
        @(negedge tck);
        #1;
        trst_n = 1'b1;
        #1;
        n_checks++;
        if ({tlr_o, ir_o, user_select_o, capture_o, shift_o, update_o, tdo_oe_o, td_o}
            !== {1'b1, 5'h01, 2'b00, 3'b000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_release: got tlr=%b ir=%h sel=%b strobes=%b%b%b oe=%b tdo=%b want 1 01 00 000 0 0",
                     tlr_o, ir_o, user_select_o, capture_o, shift_o, update_o, tdo_oe_o, td_o);
        end
        tdi = 1'b1;
        #1;
        n_checks++;
        if ({tdi_o, trst_no, tck_o} !== {1'b1, 1'b1, tck}) begin
            n_fail++;
            $display("FAIL feedthrough: got tdi/trst/tck=%b/%b/%b want 1/1/%b", tdi_o, trst_no, tck_o, tck);
        end
        step(1'b1, 1'b0);
        n_checks++;
        if ({tlr_o, ir_o} !== {1'b1, 5'h01}) begin
            n_fail++;
            $display("FAIL tlr_hold: got tlr=%b ir=%h want 1 01", tlr_o, ir_o);
        end
        step(1'b0, 1'b0);
        n_checks++;
        if (tlr_o !== 1'b0) begin
            n_fail++;
            $display("FAIL tlr_leave: got tlr=%b want 0", tlr_o);
        end
    endtask

    task automatic test_idcode_dr;
        logic [31:0] got;
        logic        oe_all;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        n_checks++;
        if ({capture_o, shift_o, update_o} !== 3'b100) begin
            n_fail++;
            $display("FAIL idcode_capture_strobe: got c/s/u=%b%b%b want 100", capture_o, shift_o, update_o);
        end
        oe_all = 1'b1;
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b0);
            got[i] = td_o;
            oe_all = oe_all & tdo_oe_o & shift_o;
        end
        n_checks++;
        if (got !== 32'h00000001) begin
            n_fail++;
            $display("FAIL idcode_shift: got %h want 00000001", got);
        end
        n_checks++;
        if (oe_all !== 1'b1) begin
            n_fail++;
            $display("FAIL idcode_oe: got oe&shift=%b want 1 throughout", oe_all);
        end
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        n_checks++;
        if ({tdo_oe_o, update_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL idcode_update: got oe=%b update=%b want 0 1", tdo_oe_o, update_o);
        end
        step(1'b0, 1'b0);
    endtask

    task automatic test_user_chain;
        logic [7:0] pat;
        logic [7:0] got;
        pat = 8'b1011_0010;
        load_ir(5'h11);
        step(1'b1, 1'b0);
        n_checks++;
        if ({ir_o, user_select_o} !== {5'h01, 2'b00}) begin
            n_fail++;
            $display("FAIL user_ir_in_update: got ir=%h sel=%b want 01 00", ir_o, user_select_o);
        end
        step(1'b0, 1'b0);
        n_checks++;
        if ({ir_o, user_select_o} !== {5'h11, 2'b10}) begin
            n_fail++;
            $display("FAIL user_select: got ir=%h sel=%b want 11 10", ir_o, user_select_o);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            user_tdo = {pat[i], ~pat[i]};
            step(1'b0, 1'b0);
            got[i] = td_o;
        end
        n_checks++;
        if (got !== pat) begin
            n_fail++;
            $display("FAIL user_tdo_mirror: got %b want %b", got, pat);
        end
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        user_tdo = 2'b00;
    endtask

    task automatic test_bypass_all_ones;
        logic [7:0] pat;
        logic [8:0] got;
        pat = 8'hA5;
        load_ir(5'h1f);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        n_checks++;
        if ({ir_o, user_select_o} !== {5'h1f, 2'b00}) begin
            n_fail++;
            $display("FAIL bypass_ir: got ir=%h sel=%b want 1f 00", ir_o, user_select_o);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        got[0] = td_o;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, pat[i]);
            got[i+1] = td_o;
        end
        n_checks++;
        if (got !== {8'hA5, 1'b0}) begin
            n_fail++;
            $display("FAIL bypass_shift: got %b want %b", got, {8'hA5, 1'b0});
        end
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic test_unused_opcode;
        logic [2:0] got;
        load_ir(5'h15);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        n_checks++;
        if ({ir_o, user_select_o} !== {5'h15, 2'b00}) begin
            n_fail++;
            $display("FAIL unused_ir: got ir=%h sel=%b want 15 00", ir_o, user_select_o);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        got[0] = td_o;
        step(1'b0, 1'b1);
        got[1] = td_o;
        step(1'b0, 1'b0);
        got[2] = td_o;
        n_checks++;
        if (got !== 3'b010) begin
            n_fail++;
            $display("FAIL unused_bypass: got %b want 010", got);
        end
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        n_checks++;
        if ({tlr_o, ir_o, user_select_o} !== {1'b1, 5'h01, 2'b00}) begin
            n_fail++;
            $display("FAIL tms_reset: got tlr=%b ir=%h sel=%b want 1 01 00", tlr_o, ir_o, user_select_o);
        end
        step(1'b0, 1'b0);
    endtask

    task automatic test_ir_capture_pause;
        logic [4:0] v;
        logic [1:0] got;
        v = 5'h11;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        got[0] = td_o;
        n_checks++;
        if (tdo_oe_o !== 1'b1 || shift_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ir_shift_oe: got oe=%b shift_o=%b want 1 0", tdo_oe_o, shift_o);
        end
        step(1'b0, v[0]);
        got[1] = td_o;
        n_checks++;
        if (got !== 2'b01) begin
            n_fail++;
            $display("FAIL ir_capture_bits: got first/second=%b/%b want 1/0", got[0], got[1]);
        end
        step(1'b1, v[1]);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        n_checks++;
        if ({tdo_oe_o, ir_o} !== {1'b0, 5'h01}) begin
            n_fail++;
            $display("FAIL ir_pause: got oe=%b ir=%h want 0 01", tdo_oe_o, ir_o);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, v[2]);
        step(1'b0, v[3]);
        step(1'b1, v[4]);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        n_checks++;
        if ({ir_o, user_select_o} !== {5'h11, 2'b10}) begin
            n_fail++;
            $display("FAIL ir_resume: got ir=%h sel=%b want 11 10", ir_o, user_select_o);
        end
    endtask

    task automatic test_testmode;
        logic [1:0] got;
        load_ir(5'h1f);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        testmode = 1'b1;
        step(1'b0, 1'b1);
        got[0] = td_o;
        step(1'b0, 1'b0);
        got[1] = td_o;
        n_checks++;
        if (got !== 2'b10) begin
            n_fail++;
            $display("FAIL testmode_rising: got first/second=%b/%b want 0/1", got[0], got[1]);
        end
        testmode = 1'b0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_shift;
        int upd_before;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        n_checks++;
        if ({td_o, tdo_oe_o, shift_o} !== 3'b111) begin
            n_fail++;
            $display("FAIL pre_reset_shift: got tdo/oe/shift=%b/%b/%b want 1/1/1", td_o, tdo_oe_o, shift_o);
        end
        upd_before = upd_cnt;
        #4;
        trst_n = 1'b0;
        #1;
        n_checks++;
        if ({td_o, tdo_oe_o, tlr_o, shift_o, ir_o, user_select_o} !== {4'b0010, 5'h01, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_mid_shift: got tdo=%b oe=%b tlr=%b shift=%b ir=%h sel=%b want 0 0 1 0 01 00",
                     td_o, tdo_oe_o, tlr_o, shift_o, ir_o, user_select_o);
        end
        tms = 1'b0;
        repeat (2) @(posedge tck);
        @(negedge tck);
        #1;
        trst_n = 1'b1;
        #1;
        n_checks++;
        if ({tlr_o, ir_o, update_o} !== {1'b1, 5'h01, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_release_mid: got tlr=%b ir=%h update=%b want 1 01 0", tlr_o, ir_o, update_o);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        n_checks++;
        if (upd_cnt !== upd_before || tlr_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_update: got update pulses=%0d tlr=%b want 0 0", upd_cnt - upd_before, tlr_o);
        end
    endtask

    initial begin
        test_reset();
        test_idcode_dr();
        test_user_chain();
        test_bypass_all_ones();
        test_unused_opcode();
        test_ir_capture_pause();
        test_testmode();
        test_reset_mid_shift();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
